// File: rtl/ldpc_pkg.sv
// Shared types, default code table and address helper for the IRA LDPC encoder.
package ldpc_pkg;

    typedef enum logic [1:0] {IDLE, INFO, PARITY} state_e;

    localparam int DEF_K       = 96;
    localparam int DEF_M       = 48;
    localparam int DEF_G       = 12;
    localparam int DEF_DEG     = 3;
    localparam int DEF_Q       = DEF_M / DEF_G;
    localparam int DEF_ENTRIES = (DEF_K / DEF_G) * DEF_DEG;
    localparam int DEF_PW      = $clog2(DEF_M);
    localparam int DEF_SW      = $clog2(DEF_M) + $clog2(DEF_G * DEF_Q);

    // One row of DEG base addresses per group of G info bits.
    localparam int DEF_ADDR_TABLE [DEF_ENTRIES] = '{
        0, 5, 9,
        2, 7, 11,
        1, 6, 10,
        3, 8, 0,
        4, 10, 2,
        11, 3, 7,
        6, 1, 9,
        8, 0, 5
    };

    function automatic int unsigned parity_addr(
        input int unsigned entry,
        input int unsigned j,
        input int unsigned g = DEF_G,
        input int unsigned q = DEF_Q,
        input int unsigned m = DEF_M
    );
        return (entry + (j % g) * q) % m;
    endfunction

endpackage

// File: rtl/ldpc_parity_acc.sv
// Parity register of the IRA encoder: scatters info bits into parity addresses,
// then shifts the parity out as a running XOR (the accumulator) beat by beat.
module ldpc_parity_acc
    import ldpc_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int K      = DEF_K,
    parameter int M      = DEF_M,
    parameter int G      = DEF_G,
    parameter int DEG    = DEF_DEG,
    parameter int ADDR_TABLE [(K / G) * DEG] = DEF_ADDR_TABLE,
    parameter int CW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              info_en,
    input  logic [CW-1:0]     info_beat,
    input  logic [DATA_W-1:0] info_bits,
    input  logic              par_en,
    output logic [DATA_W-1:0] par_bits
);

    localparam int Q  = M / G;
    localparam int NT = (K / G) * DEG;
    localparam int PW = $clog2(M);
    localparam int SW = $clog2(M) + $clog2(G * Q);
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;

    for (genvar t = 0; t < NT; t++) begin : g_tab_chk
        if (ADDR_TABLE[t] >= M || ADDR_TABLE[t] < 0) begin : g_bad
            $error("ldpc_parity_acc: ADDR_TABLE entry %0d out of range", t);
        end
    end

    logic [M-1:0]  par_d, par_q;
    logic          run_d, run_q;
    logic [SW-1:0] sum;
    logic [PW-1:0] addr;
    logic          acc;
    int            j;

    // Readout always reflects the low beat of the register; writes either
    // toggle addressed bits (info) or shift one beat out (parity).
    always_comb begin
        par_d    = par_q;
        run_d    = run_q;
        sum      = '0;
        addr     = '0;
        j        = 0;
        acc      = run_q;
        par_bits = '0;
        for (int b = 0; b < DATA_W; b++) begin
            acc         = acc ^ par_q[b];
            par_bits[b] = acc;
        end
        if (info_en) begin
            for (int b = 0; b < DATA_W; b++) begin
                if (info_bits[b]) begin
                    j = int'(info_beat) * DATA_W + b;
                    for (int d = 0; d < DEG; d++) begin
                        sum         = SW'(ADDR_TABLE[TW'((j / G) * DEG + d)]) + SW'((j % G) * Q);
                        addr        = PW'(sum % SW'(M));
                        par_d[addr] = ~par_d[addr];
                    end
                end
            end
        end else if (par_en) begin
            par_d = par_q >> DATA_W;
            run_d = acc;
        end
        if (clear) begin
            par_d = '0;
            run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
            run_q <= 1'b0;
        end else begin
            par_q <= par_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/ldpc_ira_encoder_st.sv
// Avalon-ST systematic IRA LDPC encoder: forwards K info bits, then appends
// M accumulated parity bits, forming one codeword packet per info packet.
module ldpc_ira_encoder_st
    import ldpc_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int K      = DEF_K,
    parameter int M      = DEF_M,
    parameter int G      = DEF_G,
    parameter int DEG    = DEF_DEG,
    parameter int ADDR_TABLE [(K / G) * DEG] = DEF_ADDR_TABLE
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_in_data,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_out_data,
    output logic              err_framing,
    output logic              busy
);

    localparam int INFO_BEATS = K / DATA_W;
    localparam int PAR_BEATS  = M / DATA_W;
    localparam int MAX_BEATS  = (INFO_BEATS > PAR_BEATS) ? INFO_BEATS : PAR_BEATS;
    localparam int CW         = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] LAST_INFO = CW'(INFO_BEATS - 1);
    localparam logic [CW-1:0] LAST_PAR  = CW'(PAR_BEATS - 1);
    localparam bit ONE_BEAT = (INFO_BEATS == 1);

    if (K % G != 0 || M % G != 0 || K % DATA_W != 0 || M % DATA_W != 0) begin : g_bad_cfg
        $error("ldpc_ira_encoder_st: K and M must be multiples of G and DATA_W");
    end

    state_e            state_d, state_q;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic              out_valid_d, out_valid_q;
    logic              out_sop_d, out_sop_q;
    logic              out_eop_d, out_eop_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    logic              err_d, err_q;
    logic              out_free, accept;
    logic              info_en, par_en, clear;
    logic [DATA_W-1:0] par_bits;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !reset_reset && (state_q != PARITY) && out_free;
    assign accept   = in_valid && in_ready;

    // cnt_q counts info beats in INFO and parity beats in PARITY; it is zero
    // in IDLE, so it doubles as the info beat index for the parity scatter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        info_en     = 1'b0;
        par_en      = 1'b0;
        clear       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_startofpacket) begin
                        info_en     = 1'b1;
                        out_valid_d = 1'b1;
                        out_sop_d   = 1'b1;
                        out_eop_d   = 1'b0;
                        out_data_d  = in_in_data;
                        err_d       = (in_endofpacket != ONE_BEAT);
                        if (ONE_BEAT) begin
                            state_d = PARITY;
                            cnt_d   = '0;
                        end else begin
                            state_d = INFO;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            INFO: begin
                if (accept) begin
                    info_en     = 1'b1;
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b0;
                    out_data_d  = in_in_data;
                    err_d       = in_startofpacket || (in_endofpacket != (cnt_q == LAST_INFO));
                    if (cnt_q == LAST_INFO) begin
                        state_d = PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (out_free) begin
                    par_en      = 1'b1;
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b0;
                    out_eop_d   = (cnt_q == LAST_PAR);
                    out_data_d  = par_bits;
                    if (cnt_q == LAST_PAR) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        clear   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    ldpc_parity_acc #(
        .DATA_W     (DATA_W),
        .K          (K),
        .M          (M),
        .G          (G),
        .DEG        (DEG),
        .ADDR_TABLE (ADDR_TABLE),
        .CW         (CW)
    ) u_parity_acc (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .clear     (clear),
        .info_en   (info_en),
        .info_beat (cnt_q),
        .info_bits (in_in_data),
        .par_en    (par_en),
        .par_bits  (par_bits)
    );

    assign out_valid         = out_valid_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_out_data      = out_data_q;
    assign err_framing       = err_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_ldpc_ira_encoder_st.sv
// Self-checking bench for ldpc_ira_encoder_st at DATA_W=4, default code.
module tb_ldpc_ira_encoder_st;

    localparam int DW  = 4;
    localparam int K   = 96;
    localparam int M   = 48;
    localparam int G   = 12;
    localparam int DEG = 3;
    localparam int Q   = M / G;
    localparam int IB  = K / DW;
    localparam int PB  = M / DW;
    localparam int NB  = IB + PB;
    localparam int N   = K + M;

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic          in_startofpacket = 1'b0;
    logic          in_endofpacket = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_in_data = '0;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_out_data;
    logic          err_framing;
    logic          busy;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    beat_t         mon_q[$];
    int            cyc = 0;
    int            err_cnt = 0;
    int            stall_err = 0;
    bit            rand_ready = 0;
    bit            prev_stall = 0;
    logic [DW+1:0] prev_beat = '0;
    int            n_checks = 0;
    int            n_pass = 0;

    ldpc_ira_encoder_st #(
        .DATA_W (DW),
        .K      (K),
        .M      (M),
        .G      (G),
        .DEG    (DEG)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset       (reset_reset),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_in_data        (in_in_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_out_data      (out_out_data),
        .err_framing       (err_framing),
        .busy              (busy)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= cyc + 1;

    always @(posedge clk_clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Records every transferred beat, framing pulses and any change of a stalled beat.
    always @(negedge clk_clk) begin
        if (reset_reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!out_valid ||
                {out_startofpacket, out_endofpacket, out_out_data} !== prev_beat))
                stall_err++;
            if (out_valid && out_ready)
                mon_q.push_back('{out_startofpacket, out_endofpacket, out_out_data, cyc});
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_startofpacket, out_endofpacket, out_out_data};
            if (err_framing) err_cnt++;
        end
    end

    // Codeword straight from the code definition: scatter, then prefix XOR.
    function automatic logic [N-1:0] model_cw(input logic [K-1:0] info);
        logic [M-1:0] p;
        logic [N-1:0] cw;
        logic         run;
        int           a;
        p = '0;
        for (int j = 0; j < K; j++) begin
            if (info[j]) begin
                for (int d = 0; d < DEG; d++) begin
                    a = (ldpc_pkg::DEF_ADDR_TABLE[(j / G) * DEG + d] + (j % G) * Q) % M;
                    p[a] = ~p[a];
                end
            end
        end
        cw = '0;
        cw[K-1:0] = info;
        run = 1'b0;
        for (int i = 0; i < M; i++) begin
            run = run ^ p[i];
            cw[K+i] = run;
        end
        return cw;
    endfunction

    task automatic send_frame(input logic [K-1:0] info, input int eop_beat, output bit ok);
        bit got;
        ok = 1;
        for (int k = 0; k < IB && ok; k++) begin
            got = 0;
            in_valid         = 1'b1;
            in_in_data       = info[k*DW +: DW];
            in_startofpacket = (k == 0);
            in_endofpacket   = (k == eop_beat);
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk_clk);
                got = in_ready;
                @(posedge clk_clk);
                #1;
            end
            ok = got;
        end
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clk_clk);
            #1;
            ok = (mon_q.size() >= n);
        end
        repeat (3) @(posedge clk_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [DW+5:0] got;
        reset_reset = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;
        got = {out_valid, out_startofpacket, out_endofpacket, out_out_data, err_framing, busy, in_ready};
        n_checks++;
        if (got === '0) n_pass++;
        else $display("[TB] FAIL reset_outputs: got %b, required all zero", got);
        reset_reset = 1'b0;
        @(posedge clk_clk);
        #1;
        n_checks++;
        if (in_ready === 1'b1 && busy === 1'b0) n_pass++;
        else $display("[TB] FAIL idle_ready: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    endtask

    // Two all-zero frames with the sink always ready: output must be gap-free.
    task automatic test_zero_back_to_back();
        bit ok1, ok2, okw;
        logic [DW+1:0] exp_b, got_b;
        mon_q.delete();
        err_cnt = 0;
        send_frame('0, IB - 1, ok1);
        send_frame('0, IB - 1, ok2);
        wait_beats(2 * NB, okw);
        n_checks++;
        if (ok1 && ok2 && okw && mon_q.size() == 2 * NB) n_pass++;
        else $display("[TB] FAIL zero_count: got %0d beats, required %0d", mon_q.size(), 2 * NB);
        for (int k = 0; k < 2 * NB; k++) begin
            exp_b = {k % NB == 0, k % NB == NB - 1, DW'(0)};
            got_b = (k < mon_q.size()) ? {mon_q[k].sop, mon_q[k].eop, mon_q[k].data} : 'x;
            n_checks++;
            if (got_b === exp_b) n_pass++;
            else $display("[TB] FAIL zero_beat[%0d]: got %b, required %b", k, got_b, exp_b);
        end
        n_checks++;
        if (mon_q.size() == 2 * NB && mon_q[2*NB-1].cyc - mon_q[0].cyc == 2 * NB - 1) n_pass++;
        else $display("[TB] FAIL zero_throughput: span %0d, required %0d",
                      (mon_q.size() > 0) ? mon_q[mon_q.size()-1].cyc - mon_q[0].cyc : -1, 2 * NB - 1);
        n_checks++;
        if (err_cnt == 0) n_pass++;
        else $display("[TB] FAIL zero_err: got %0d pulses, required 0", err_cnt);
    endtask

    // Single info bit set: parity checked against hand-derived bit ranges.
    task automatic test_single_bits();
        logic [K-1:0] info;
        logic [N-1:0] got_cw;
        logic [M-1:0] exp_p;
        bit ok, okw;
        for (int t = 0; t < 2; t++) begin
            info = '0;
            info[t] = 1'b1;
            for (int i = 0; i < M; i++)
                exp_p[i] = (t == 0) ? (i <= 4 || i >= 9) : ((i >= 4 && i <= 8) || i >= 13);
            mon_q.delete();
            send_frame(info, IB - 1, ok);
            wait_beats(NB, okw);
            got_cw = '0;
            for (int k = 0; k < NB && k < mon_q.size(); k++) got_cw[k*DW +: DW] = mon_q[k].data;
            n_checks++;
            if (ok && okw && got_cw[K-1:0] === info) n_pass++;
            else $display("[TB] FAIL bit%0d_info: got %h, required %h", t, got_cw[K-1:0], info);
            n_checks++;
            if (got_cw[N-1:K] === exp_p) n_pass++;
            else $display("[TB] FAIL bit%0d_parity: got %b, required %b", t, got_cw[N-1:K], exp_p);
        end
    endtask

    // Random frames, random sink stalls, compared beat by beat against the model.
    task automatic test_random_backpressure();
        logic [K-1:0]  info;
        logic [N-1:0]  cw;
        logic [DW+1:0] exp_q[$];
        logic [DW+1:0] got_b;
        bit ok, okw, all_ok;
        mon_q.delete();
        err_cnt = 0;
        stall_err = 0;
        rand_ready = 1;
        all_ok = 1;
        for (int f = 0; f < 3; f++) begin
            info = {$urandom, $urandom, $urandom};
            cw = model_cw(info);
            for (int k = 0; k < NB; k++) exp_q.push_back({k == 0, k == NB - 1, cw[k*DW +: DW]});
            send_frame(info, IB - 1, ok);
            all_ok = all_ok && ok;
        end
        wait_beats(3 * NB, okw);
        rand_ready = 0;
        n_checks++;
        if (all_ok && okw && mon_q.size() == exp_q.size()) n_pass++;
        else $display("[TB] FAIL rand_count: got %0d beats, required %0d", mon_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            got_b = (k < mon_q.size()) ? {mon_q[k].sop, mon_q[k].eop, mon_q[k].data} : 'x;
            n_checks++;
            if (got_b === exp_q[k]) n_pass++;
            else $display("[TB] FAIL rand_beat[%0d]: got %b, required %b", k, got_b, exp_q[k]);
        end
        n_checks++;
        if (stall_err == 0) n_pass++;
        else $display("[TB] FAIL rand_stall_stable: got %0d changes, required 0", stall_err);
        n_checks++;
        if (err_cnt == 0) n_pass++;
        else $display("[TB] FAIL rand_err: got %0d pulses, required 0", err_cnt);
    endtask

    task automatic test_framing();
        logic [K-1:0]  info;
        logic [N-1:0]  cw;
        logic [DW+1:0] exp_b, got_b;
        bit got, ok, okw;
        mon_q.delete();
        err_cnt = 0;
        in_valid = 1'b1;
        in_in_data = 4'hA;
        @(negedge clk_clk);
        got = in_ready;
        @(posedge clk_clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        n_checks++;
        if (got && err_cnt == 1 && mon_q.size() == 0 && busy === 1'b0) n_pass++;
        else $display("[TB] FAIL stray_beat: accepted=%0d err=%0d beats=%0d busy=%b, required 1 1 0 0",
                      got, err_cnt, mon_q.size(), busy);
        info = {$urandom, $urandom, $urandom};
        cw = model_cw(info);
        send_frame(info, 12, ok);
        wait_beats(NB, okw);
        n_checks++;
        if (ok && okw && err_cnt == 3) n_pass++;
        else $display("[TB] FAIL early_eop_err: got %0d pulses, required 3", err_cnt);
        for (int k = 0; k < NB; k++) begin
            exp_b = {k == 0, k == NB - 1, cw[k*DW +: DW]};
            got_b = (k < mon_q.size()) ? {mon_q[k].sop, mon_q[k].eop, mon_q[k].data} : 'x;
            n_checks++;
            if (got_b === exp_b) n_pass++;
            else $display("[TB] FAIL early_eop_beat[%0d]: got %b, required %b", k, got_b, exp_b);
        end
    endtask

    task automatic test_reset_mid_parity();
        logic [K-1:0]  info;
        logic [N-1:0]  cw;
        logic [DW+1:0] exp_b, got_b;
        bit ok, okw;
        int eops;
        mon_q.delete();
        info = {$urandom, $urandom, $urandom};
        send_frame(info, IB - 1, ok);
        okw = 0;
        for (int c = 0; c < 500 && !okw; c++) begin
            @(posedge clk_clk);
            #1;
            okw = (mon_q.size() >= IB + 5);
        end
        @(posedge clk_clk);
        #3;
        reset_reset = 1'b1;
        #1;
        eops = 0;
        foreach (mon_q[i]) if (mon_q[i].eop) eops++;
        n_checks++;
        if (ok && okw && out_valid === 1'b0 && busy === 1'b0 && eops == 0) n_pass++;
        else $display("[TB] FAIL reset_abort: out_valid=%b busy=%b eops=%0d, required 0 0 0",
                      out_valid, busy, eops);
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        mon_q.delete();
        err_cnt = 0;
        info = {$urandom, $urandom, $urandom};
        cw = model_cw(info);
        send_frame(info, IB - 1, ok);
        wait_beats(NB, okw);
        n_checks++;
        if (ok && okw && mon_q.size() == NB && err_cnt == 0) n_pass++;
        else $display("[TB] FAIL post_reset_count: got %0d beats err=%0d, required %0d 0",
                      mon_q.size(), err_cnt, NB);
        for (int k = 0; k < NB; k++) begin
            exp_b = {k == 0, k == NB - 1, cw[k*DW +: DW]};
            got_b = (k < mon_q.size()) ? {mon_q[k].sop, mon_q[k].eop, mon_q[k].data} : 'x;
            n_checks++;
            if (got_b === exp_b) n_pass++;
            else $display("[TB] FAIL post_reset_beat[%0d]: got %b, required %b", k, got_b, exp_b);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_zero_back_to_back();
        test_single_bits();
        test_random_backpressure();
        test_framing();
        test_reset_mid_parity();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ldpc_ira_encoder_st.md
Name: ldpc_ira_encoder_st

Overview:
- Parametrised systematic LDPC encoder with IRA (irregular repeat-accumulate) structure and Avalon-ST in/out.
- Successor to the fixed 1-bit encoder: configurable beat width, code size and parity-address table; built-in frame-length checking.
- Sits between the bit-source framer and the modulator mapper; each K-bit info packet becomes one N=K+M-bit codeword packet (info bits followed by parity bits).

Parameters:
DATA_W, 1, bits per beat; K and M must be multiples of DATA_W.
K, 96, info bits per codeword.
M, 48, parity bits per codeword.
G, 12, info bits per address group; K%G==0; Q=M/G must be an integer.
DEG, 3, parity addresses per info bit.
ADDR_TABLE, ldpc_pkg default, (K/G)*DEG entries of clog2(M) bits; group0 default = {0,5,9}.

Ports:
clk_clk  in  1  clock.
reset_reset  in  1  asynchronous active-high reset.
in_startofpacket  in  1  first info beat.
in_endofpacket  in  1  last info beat; checked only, not used for control.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accept.
in_in_data  in  DATA_W  info bits; bit0 is the earliest in time.
out_startofpacket  out  1  first codeword beat.
out_endofpacket  out  1  last parity beat.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accept.
out_out_data  out  DATA_W  codeword bits; bit0 is the earliest.
err_framing  out  1  one-cycle pulse on a framing error.
busy  out  1  high in INFO or PARITY.

Behaviour:
- Reset values: all outputs 0; state IDLE; parity register 0; counters 0. Reset asserted mid-frame aborts the frame immediately; no eop is emitted.
- Output stage:
  - Single register stage. Transfer occurs when out_valid&&out_ready.
  - in_ready = (state!=PARITY) && (!out_valid || out_ready).
  - Latency from input accept to output valid is 1 cycle. Full throughput: 1 beat/cycle with no bubbles.
- IDLE:
  - Beat with sop accepted → INFO, bit counter = 0, beat processed as info.
  - Beat without sop is accepted and dropped, with err_framing pulse.
- INFO:
  - Each accepted beat is copied to the output register. out_startofpacket=1 on info beat 0 only.
  - For each info bit j (value 1): toggle parity bits at (ADDR_TABLE[j/G][d] + (j%G)*Q) mod M for d=0..DEG-1.
  - Multiple toggles of the same address within one beat XOR-combine.
- Framing checks (err_framing pulse, control unaffected):
  - sop seen on a beat other than beat 0.
  - eop seen on a beat other than the last info beat.
  - eop missing on the last info beat.
- Counter reaching K after the last info beat → PARITY. The transition occurs after the beat is loaded, so there is no gap.
- PARITY:
  - in_ready=0. Emits M/DATA_W beats, each loaded when the output register is free.
  - Output parity bit i = p_0 ^ … ^ p_i (accumulator), computed with a running-XOR bit carried across beats.
  - out_endofpacket=1 on the final beat, after which the state returns to IDLE and the parity register and running bit clear.
  - A new sop can be accepted the cycle after the final parity beat loads.
- Back-pressure: with out_ready=0 the output register holds its data and sideband stable. No input is accepted while the register is full.
- Simultaneous events: the last info beat accept and the first parity load never share a cycle. The eop output beat and the next frame's sop input may share a cycle.
- Arithmetic:
  - Address computed at clog2(M)+clog2(G*Q) width before mod M.
  - Elaboration assertion fails if K%G, M%G, K%DATA_W or M%DATA_W is non-zero, or if any table entry is ≥M.

Decomposition:
- ldpc_pkg:
  - state enum {IDLE, INFO, PARITY}.
  - Default ADDR_TABLE constant.
  - clog2-based width constants.
  - Function parity_addr(entry, j) for tables and for bench reference-model reuse.
- Sub-module ldpc_parity_acc: parity register, per-beat address generation and XOR update, and prefix-XOR readout with the running bit. The top-level module holds the FSM, counters, framing checks and the output register.

Test Plan:
- Default params, all-zero 96-bit packet, out_ready=1 → 144 output beats, bits all 0, sop on beat 0, eop on beat 143, err_framing never set.
- Info bit0=1, rest 0 → parity p toggled at {0,5,9}. Output parity bits 0–4=1, 5–8=0, 9–47=1.
- Info bit1=1 only → toggles at {4,9,13}. Parity 0–3=0, 4–8=1, 9–12=0, 13–47=1.
- DATA_W=4, random data, random out_ready (50%) → matches the package reference model bit-exactly. No beat is lost or duplicated; data is held stable while stalled.
- Beat without sop in IDLE → dropped, err_framing pulse. Early eop at beat 50 → err_framing pulse, encoding continues to 96 bits.
- Reset asserted at parity beat 20 → out_valid 0 asynchronously. Next packet encodes correctly from a zero parity state.
